// File: rtl/layer_compositor.sv
// layer_compositor: two-stage pixel compositor. Merges prioritised layer
// colours with a transparent key, overlays blinking indicator squares,
// and delays the sync/blank signals so they stay aligned with colour.
module layer_compositor #(
    parameter int NUM_LAYERS   = 12,
    parameter int COLOR_W      = 12,
    parameter int NUM_IND      = 2,
    parameter int IND_SIZE     = 20,
    parameter int BLINK_FRAMES = 30,
    parameter int IDX_W        = 4
) (
    input  logic                          ClkPort,
    input  logic                          Reset_n,
    input  logic                          bright_in,
    input  logic                          hsync_in,
    input  logic                          vsync_in,
    input  logic [9:0]                    hCount,
    input  logic [9:0]                    vCount,
    input  logic [NUM_LAYERS*COLOR_W-1:0] layer_rgb,
    input  logic [NUM_LAYERS-1:0]         layer_en,
    input  logic [COLOR_W-1:0]            key_color,
    input  logic [COLOR_W-1:0]            bg_color,
    input  logic [NUM_IND-1:0]            ind_on,
    input  logic [NUM_IND-1:0]            ind_blink,
    input  logic [NUM_IND*10-1:0]         ind_x,
    input  logic [NUM_IND*10-1:0]         ind_y,
    input  logic [NUM_IND*COLOR_W-1:0]    ind_color,
    output logic                          hSync,
    output logic                          vSync,
    output logic [3:0]                    vgaR,
    output logic [3:0]                    vgaG,
    output logic [3:0]                    vgaB,
    output logic                          top_valid,
    output logic [IDX_W-1:0]              top_layer,
    output logic [15:0]                   frame_count
);

    // Stage 1 registers
    logic [NUM_LAYERS*COLOR_W-1:0] s1_rgb;
    logic [NUM_LAYERS-1:0]         s1_en;
    logic                          s1_bright;
    logic                          s1_hs;
    logic                          s1_vs;
    logic [NUM_IND-1:0]            s1_hit;

    // Stage 2 registers
    logic [COLOR_W-1:0]            rgb_q;
    logic                          valid_q;
    logic [IDX_W-1:0]              idx_q;
    logic                          hs_q;
    logic                          vs_q;

    // Frame / blink state
    logic                          vs_prev;
    logic [15:0]                   frame_q;
    logic [7:0]                    blink_cnt;
    logic                          blink_phase;
    logic                          frame_edge;

    // Combinational intermediates
    logic [10:0]                   hx;
    logic [10:0]                   vy;
    logic [NUM_IND-1:0]            ind_hit;
    logic [COLOR_W-1:0]            res_rgb;
    logic                          res_valid;
    logic [IDX_W-1:0]              res_idx;

    assign hx = {1'b0, hCount};
    assign vy = {1'b0, vCount};
    assign frame_edge = vs_prev && !vsync_in;

    // Indicator hit test; 11-bit compares so the far edge never wraps
    always_comb begin
        ind_hit = '0;
        for (int unsigned k = 0; k < NUM_IND; k++) begin
            ind_hit[k] = ind_on[k]
                && (hx >= {1'b0, ind_x[k*10 +: 10]})
                && (hx <  ({1'b0, ind_x[k*10 +: 10]} + 11'(IND_SIZE)))
                && (vy >= {1'b0, ind_y[k*10 +: 10]})
                && (vy <  ({1'b0, ind_y[k*10 +: 10]} + 11'(IND_SIZE)))
                && (!ind_blink[k] || blink_phase);
        end
    end

    // Stage 1: capture the pixel inputs, sync/blank and indicator hits
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            s1_rgb    <= '0;
            s1_en     <= '0;
            s1_bright <= 1'b0;
            s1_hs     <= 1'b1;
            s1_vs     <= 1'b1;
            s1_hit    <= '0;
        end else begin
            s1_rgb    <= layer_rgb;
            s1_en     <= layer_en;
            s1_bright <= bright_in;
            s1_hs     <= hsync_in;
            s1_vs     <= vsync_in;
            s1_hit    <= ind_hit;
        end
    end

    // Resolve: layers by ascending index, then indicators, then blanking,
    // each later pass overriding the earlier so the highest priority wins
    always_comb begin
        res_rgb   = bg_color;
        res_valid = 1'b0;
        res_idx   = '0;
        for (int unsigned i = 0; i < NUM_LAYERS; i++) begin
            if (s1_en[i] && (s1_rgb[i*COLOR_W +: COLOR_W] != key_color)) begin
                res_rgb   = s1_rgb[i*COLOR_W +: COLOR_W];
                res_valid = 1'b1;
                res_idx   = IDX_W'(i);
            end
        end
        for (int unsigned k = 0; k < NUM_IND; k++) begin
            if (s1_hit[k]) begin
                res_rgb   = ind_color[k*COLOR_W +: COLOR_W];
                res_valid = 1'b0;
                res_idx   = '0;
            end
        end
        if (!s1_bright) begin
            res_rgb   = '0;
            res_valid = 1'b0;
            res_idx   = '0;
        end
    end

    // Stage 2: register resolved colour, winning index and delayed syncs
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            rgb_q   <= '0;
            valid_q <= 1'b0;
            idx_q   <= '0;
            hs_q    <= 1'b1;
            vs_q    <= 1'b1;
        end else begin
            rgb_q   <= res_rgb;
            valid_q <= res_valid;
            idx_q   <= res_idx;
            hs_q    <= s1_hs;
            vs_q    <= s1_vs;
        end
    end

    // Frame counter and blink phase, advanced on each vsync falling edge
    always_ff @(posedge ClkPort or negedge Reset_n) begin
        if (!Reset_n) begin
            vs_prev     <= 1'b1;
            frame_q     <= '0;
            blink_cnt   <= '0;
            blink_phase <= 1'b0;
        end else begin
            vs_prev <= vsync_in;
            if (frame_edge) begin
                frame_q <= frame_q + 16'd1;
                if (blink_cnt == 8'(BLINK_FRAMES - 1)) begin
                    blink_cnt   <= '0;
                    blink_phase <= !blink_phase;
                end else begin
                    blink_cnt <= blink_cnt + 8'd1;
                end
            end
        end
    end

    assign hSync       = hs_q;
    assign vSync       = vs_q;
    assign vgaR        = rgb_q[11:8];
    assign vgaG        = rgb_q[7:4];
    assign vgaB        = rgb_q[3:0];
    assign top_valid   = valid_q;
    assign top_layer   = idx_q;
    assign frame_count = frame_q;

endmodule

// File: doc/layer_compositor.md
Name: layer_compositor

Overview:
Parametrised, pipelined pixel compositor that replaces the hand-written per-sprite priority chain in the VGA top level.
- Merges NUM_LAYERS sprite/controller RGB streams by fixed priority, with a programmable transparent key colour and per-layer enables.
- Draws NUM_IND rectangular status indicators above all layers; each indicator can blink at a frame-counted rate.
- Delays hSync/vSync to match pixel latency, and drives vgaR/vgaG/vgaB directly.

Parameters:
NUM_LAYERS, 12, number of input layers; index 0 = lowest priority
COLOR_W, 12, RGB width (4:4:4)
NUM_IND, 2, number of indicator squares
IND_SIZE, 20, indicator side length in pixels
BLINK_FRAMES, 30, frames per blink half-period (1..255)
IDX_W, 4, width of layer index output (must satisfy 2^IDX_W >= NUM_LAYERS)

Ports:
ClkPort  in  1  pixel-domain clock (same clock as display_controller)
Reset_n  in  1  asynchronous, active-low reset
bright_in  in  1  active-video flag from display_controller
hsync_in  in  1  raw hSync (active low)
vsync_in  in  1  raw vSync (active low)
hCount  in  10  current pixel column
vCount  in  10  current pixel row
layer_rgb  in  NUM_LAYERS*COLOR_W  packed layer colours; layer i = bits [i*COLOR_W +: COLOR_W]
layer_en  in  NUM_LAYERS  per-layer enable
key_color  in  COLOR_W  transparent colour (the background a controller outputs when not drawing)
bg_color  in  COLOR_W  colour shown where nothing is opaque
ind_on  in  NUM_IND  indicator active (e.g. in_door, in_seat)
ind_blink  in  NUM_IND  indicator blinks when 1
ind_x  in  NUM_IND*10  packed left edge per indicator
ind_y  in  NUM_IND*10  packed top edge per indicator
ind_color  in  NUM_IND*COLOR_W  packed indicator colour
hSync  out  1  delayed hSync
vSync  out  1  delayed vSync
vgaR, vgaG, vgaB  out  4 each  pixel colour = rgb[11:8], [7:4], [3:0]
top_valid  out  1  1 when output pixel comes from a layer (not bg, not indicator, not blanking)
top_layer  out  IDX_W  index of winning layer; 0 when top_valid = 0
frame_count  out  16  frames elapsed since reset; wraps at 0xFFFF -> 0

Behaviour:
- Reset (Reset_n low, async):
  - all pipeline registers cleared;
  - vga outputs 0; hSync = 1, vSync = 1;
  - top_valid = 0, top_layer = 0;
  - frame_count = 0, blink counter = 0, blink_phase = 0.
- Pipeline: exactly 2 ClkPort cycles of latency, one pixel per cycle, no stalls.
  - Stage 1 registers layer_rgb, layer_en, bright_in, hsync_in, vsync_in, and per-indicator hit bits.
  - Stage 2 registers the resolved colour, index and syncs.
  - hSync/vSync/bright see the same 2-cycle delay as colour.
- Indicator hit for indicator k: ind_on[k] && hCount in [ind_x, ind_x+IND_SIZE) && vCount in [ind_y, ind_y+IND_SIZE) && (!ind_blink[k] || blink_phase).
  - Compares use 11-bit arithmetic so ind_x + IND_SIZE never wraps.
- Resolution, in decreasing priority:
  1. Delayed bright = 0 -> black (12'h000), top_valid = 0.
  2. Highest-index indicator with a hit -> its ind_color, top_valid = 0.
  3. Highest-index layer i with layer_en[i] = 1 and layer_rgb[i] != key_color -> that colour, top_valid = 1, top_layer = i.
  4. Otherwise -> bg_color, top_valid = 0.
- A layer whose colour equals key_color is transparent even when enabled. bg_color may equal key_color.
- Frame counting:
  - Frame boundary = falling edge of vsync_in, detected with a registered copy of the input.
  - Each boundary increments frame_count and the blink counter.
  - When the blink counter reaches BLINK_FRAMES-1 at a boundary, it clears to 0 and blink_phase toggles.
  - Blink_phase therefore toggles every BLINK_FRAMES frames.
- Inputs that change mid-frame take effect at the next pixel; no shadowing.
- Reset asserted mid-frame: outputs return to reset values immediately. After release, the first valid pixel appears 2 cycles later and blink restarts at phase 0.
- ind_x/ind_y beyond the visible area: the indicator is simply never hit. No error.

Test Plan:
- Reset: hold Reset_n = 0 with random inputs -> vga = 0, hSync = vSync = 1, frame_count = 0. Release, drive bright_in = 1 -> first resolved pixel after exactly 2 cycles.
- Priority: layer 2 = 12'hF00, layer 7 = 12'h0F0, all enabled, key = 12'hFFF -> output 12'h0F0, top_layer = 7. Clear layer_en[7] -> 12'hF00, top_layer = 2.
- Transparency: set layer 7 = 12'hFFF (= key), bg = 12'h123 -> layer 2 colour shows. Set all layers to key -> 12'h123, top_valid = 0.
- Indicator: ind_on[0] = 1, x = 750, y = 50, colour 12'h0F0. Pixel (750,50) and (769,69) -> 12'h0F0; (770,50) -> layer colour. Indicator 1 overlapping with colour 12'h00F -> 12'h00F wins.
- Blink, with BLINK_FRAMES = 2 and ind_blink[0] = 1:
  - Frames 0-1 -> indicator hidden.
  - After the 2nd vsync falling edge -> shown.
  - After the 4th -> hidden.
  - frame_count = 4.
- Blanking and sync: bright_in = 0 over opaque layers -> black. hsync_in pulse of 96 cycles -> identical 96-cycle pulse on hSync, 2 cycles later.
